// File: rtl/mem_ss_pkg.sv
// Shared memory-subsystem AXI widths, response/burst encodings and the
// traffic-generator FSM state type.
package mem_ss_pkg;

    localparam int AXI_MEM_DATA_WIDTH      = 512;
    localparam int AXI_MEM_ADDR_WIDTH      = 32;
    localparam int AXI_MEM_ID_WIDTH        = 9;
    localparam int AXI_MEM_USER_WIDTH      = 1;
    localparam int AXI_MEM_BURST_LEN_WIDTH = 8;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW,
        WR_W,
        WR_B,
        RD_AR,
        RD_R,
        DONE
    } tg_state_e;

    // Lengths of the form 2^n-1 up to 63 keep a burst inside one 4 KB page.
    function automatic logic len_legal(input logic [7:0] len);
        return (len <= 8'd63) && ((len & (len + 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/mem_tg_pattern_gen.sv
// Deterministic beat pattern: 32-bit lane k of beat b = seed + b*lanes + k.
module mem_tg_pattern_gen #(
    parameter int DATA_W = 512
) (
    input  logic [31:0]       seed,
    input  logic [31:0]       beat,
    output logic [DATA_W-1:0] data
);

    localparam int NUM_LANES = DATA_W / 32;

    logic [NUM_LANES-1:0][31:0] lanes;
    logic [31:0]                lane0;

    assign lane0 = seed + beat * 32'(NUM_LANES);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lanes[k] = lane0 + 32'(k);
    end

    assign data = lanes;

endmodule

// File: rtl/mem_axi_tg_chk.sv
// AXI4 write-then-readback traffic generator/checker for one memory channel.
// One transaction outstanding at a time; every read beat is compared.
module mem_axi_tg_chk
    import mem_ss_pkg::*;
#(
    parameter int DATA_W = AXI_MEM_DATA_WIDTH,
    parameter int ADDR_W = AXI_MEM_ADDR_WIDTH,
    parameter int ID_W   = AXI_MEM_ID_WIDTH,
    parameter int USER_W = AXI_MEM_USER_WIDTH,
    parameter int LEN_W  = AXI_MEM_BURST_LEN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [15:0]         num_bursts,
    input  logic [31:0]         seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                cfg_err,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [LEN_W-1:0]    m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [USER_W-1:0]   m_awuser,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic [USER_W-1:0]   m_wuser,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [LEN_W-1:0]    m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [USER_W-1:0]   m_aruser,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast
);

    localparam int         BYTES  = DATA_W / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));

    tg_state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       nb_q, nb_d;
    logic [31:0]       seed_q, seed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       bcnt_q, bcnt_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [31:0]       gbeat_q, gbeat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              cfg_err_q, cfg_err_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;

    logic [DATA_W-1:0] wpat, rpat;
    logic [ADDR_W-1:0] stride, rbeat_addr, err_addr;
    logic              cfg_ok, last_beat, last_burst;
    logic              w_fire, b_fire, r_fire, b_err, r_err;
    logic              unused_rid;

    mem_tg_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
        .seed (seed_q),
        .beat (gbeat_q),
        .data (wpat)
    );

    mem_tg_pattern_gen #(.DATA_W(DATA_W)) u_rd_pat (
        .seed (seed_q),
        .beat (gbeat_q),
        .data (rpat)
    );

    assign unused_rid = ^m_rid;

    assign cfg_ok     = len_legal(8'(burst_len)) && (base_addr[11:0] == 12'd0);
    assign stride     = ADDR_W'((32'(len_q) + 32'd1) * 32'(BYTES));
    assign rbeat_addr = addr_q + ADDR_W'(beat_q) * ADDR_W'(BYTES);
    assign last_beat  = (beat_q == len_q);
    assign last_burst = (bcnt_q == nb_q - 16'd1);

    assign w_fire = (state_q == WR_W) && m_wready;
    assign b_fire = (state_q == WR_B) && m_bvalid;
    assign r_fire = (state_q == RD_R) && m_rvalid;
    assign b_err  = b_fire && ((m_bresp != AXI_RESP_OKAY) || (m_bid != '0));
    assign r_err  = r_fire && ((m_rdata != rpat) || (m_rresp != AXI_RESP_OKAY) ||
                               (m_rlast != last_beat));
    // A bad write response is blamed on the burst start address.
    assign err_addr = (state_q == WR_B) ? addr_q : rbeat_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && cfg_ok && (num_bursts != 16'd0)) state_d = WR_AW;
            WR_AW:   if (m_awready) state_d = WR_W;
            WR_W:    if (m_wready && last_beat) state_d = WR_B;
            WR_B:    if (m_bvalid) state_d = last_burst ? RD_AR : WR_AW;
            RD_AR:   if (m_arready) state_d = RD_R;
            RD_R:    if (m_rvalid && last_beat) state_d = last_burst ? DONE : RD_AR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_awvalid = (state_q == WR_AW);
        m_wvalid  = (state_q == WR_W);
        m_bready  = (state_q == WR_B);
        m_arvalid = (state_q == RD_AR);
        m_rready  = (state_q == RD_R);
    end

    assign m_awid    = '0;
    assign m_awaddr  = addr_q;
    assign m_awlen   = len_q;
    assign m_awsize  = AXSIZE;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awuser  = '0;
    assign m_wdata   = wpat;
    assign m_wstrb   = '1;
    assign m_wlast   = last_beat;
    assign m_wuser   = '0;
    assign m_arid    = '0;
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = AXSIZE;
    assign m_arburst = AXI_BURST_INCR;
    assign m_aruser  = '0;

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        nb_d      = nb_q;
        seed_d    = seed_q;
        addr_d    = addr_q;
        bcnt_d    = bcnt_q;
        beat_d    = beat_q;
        gbeat_d   = gbeat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        cfg_err_d = cfg_err_q;
        err_d     = err_q;
        ferr_d    = ferr_q;

        if ((state_q == IDLE) && start) begin
            base_d    = base_addr;
            len_d     = burst_len;
            nb_d      = num_bursts;
            seed_d    = seed;
            addr_d    = base_addr;
            bcnt_d    = '0;
            beat_d    = '0;
            gbeat_d   = '0;
            err_d     = '0;
            ferr_d    = '0;
            cfg_err_d = !cfg_ok;
            busy_d    = cfg_ok && (num_bursts != 16'd0);
            done_d    = !cfg_ok || (num_bursts == 16'd0);
            pass_d    = cfg_ok && (num_bursts == 16'd0);
        end

        if (w_fire || r_fire) begin
            beat_d  = last_beat ? '0 : beat_q + LEN_W'(1);
            gbeat_d = gbeat_q + 32'd1;
        end

        // Burst boundary; wrapping to base rewinds the pattern for read-back.
        if (b_fire || (r_fire && last_beat)) begin
            if (last_burst) begin
                bcnt_d  = '0;
                addr_d  = base_q;
                gbeat_d = '0;
            end else begin
                bcnt_d  = bcnt_q + 16'd1;
                addr_d  = addr_q + stride;
            end
        end

        if (b_err || r_err) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    ferr_d = err_addr;
        end

        if (state_q == DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_q == 16'd0) && !cfg_err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            nb_q      <= '0;
            seed_q    <= '0;
            addr_q    <= '0;
            bcnt_q    <= '0;
            beat_q    <= '0;
            gbeat_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
        end else begin
            base_q    <= base_d;
            len_q     <= len_d;
            nb_q      <= nb_d;
            seed_q    <= seed_d;
            addr_q    <= addr_d;
            bcnt_q    <= bcnt_d;
            beat_q    <= beat_d;
            gbeat_q   <= gbeat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            cfg_err_q <= cfg_err_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign cfg_err        = cfg_err_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_mem_axi_tg_chk.sv
// Bench for mem_axi_tg_chk: behavioural AXI memory responder with random
// back-pressure and fault injection, checked against expected outcomes.
module tb_mem_axi_tg_chk;

    localparam int DW = 512, AW = 32, IDW = 9, UW = 1, LW = 8, BY = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            start;
    logic [AW-1:0]   base_addr;
    logic [LW-1:0]   burst_len;
    logic [15:0]     num_bursts;
    logic [31:0]     seed;
    logic            busy, done, pass, cfg_err;
    logic [15:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic            m_awvalid, m_awready;
    logic [IDW-1:0]  m_awid;
    logic [AW-1:0]   m_awaddr;
    logic [LW-1:0]   m_awlen;
    logic [2:0]      m_awsize;
    logic [1:0]      m_awburst;
    logic [UW-1:0]   m_awuser;
    logic            m_wvalid, m_wready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wlast;
    logic [UW-1:0]   m_wuser;
    logic            m_bvalid, m_bready;
    logic [IDW-1:0]  m_bid;
    logic [1:0]      m_bresp;
    logic            m_arvalid, m_arready;
    logic [IDW-1:0]  m_arid;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic [UW-1:0]   m_aruser;
    logic            m_rvalid, m_rready;
    logic [IDW-1:0]  m_rid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;

    mem_axi_tg_chk #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IDW), .USER_W(UW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
        .num_bursts(num_bursts), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .cfg_err(cfg_err), .err_count(err_count), .first_err_addr(first_err_addr),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awuser(m_awuser),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wuser(m_wuser),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_aruser(m_aruser),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] s, input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = s + 32'(b) * 32'(DW / 32) + 32'(k);
        return r;
    endfunction

    // Test-control knobs, written only by the main sequence.
    int          rdy_pct = 100, inj_b = -1, inj_r = -1, clr_req = 0;
    logic [31:0] exp_seed = '0;

    // Responder state and logs, written only by the responder process.
    logic [DW-1:0] mem [logic [31:0]];
    logic [31:0]   aw_log[$], ar_log[$];
    int            clr_ack, aw_seen, w_cnt, w_bad, wlast_bad, fld_bad, b_idx, r_g;
    logic [31:0]   w_lane0, w_addr, r_addr;
    logic [7:0]    w_len, r_len;
    int            w_beat, r_beat, bdly;
    logic          b_pend, b_fire, r_act, r_fire;
    int            aw_hold_f = 0, w_hold_f = 0, ar_hold_f = 0;

    task automatic resp_reset();
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bid = '0; m_bresp = '0;
        m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
        b_pend = 0; b_fire = 0; r_act = 0; r_fire = 0; bdly = 0;
        w_addr = '0; w_len = '0; w_beat = 0; r_addr = '0; r_len = '0; r_beat = 0;
    endtask

    task automatic log_clear();
        aw_log.delete(); ar_log.delete();
        aw_seen = 0; w_cnt = 0; w_bad = 0; wlast_bad = 0; fld_bad = 0;
        b_idx = 0; r_g = 0; w_lane0 = '0;
    endtask

    // Decisions made on the falling edge take effect at the next rising edge;
    // DUT valids/readies depend only on its state, so they are stable here.
    initial begin
        resp_reset();
        log_clear();
        clr_ack = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_reset();
                continue;
            end
            if (clr_ack != clr_req) begin
                log_clear();
                clr_ack = clr_req;
            end
            if (r_fire) begin
                m_rvalid = 0; r_fire = 0; r_beat++; r_g++;
                if (r_beat > int'(r_len)) r_act = 0;
            end
            if (r_act && !m_rvalid && ($urandom_range(99) < rdy_pct)) begin
                m_rdata = mem[r_addr + 32'(r_beat * BY)];
                if (r_g == inj_r) m_rdata[0] = ~m_rdata[0];
                m_rlast = (r_beat == int'(r_len));
                m_rresp = 2'b00;
                m_rvalid = 1;
            end
            r_fire = m_rvalid && m_rready;
            if (b_fire) begin
                m_bvalid = 0; b_fire = 0; b_idx++;
            end
            if (b_pend && !m_bvalid) begin
                if (bdly == 0) begin
                    m_bvalid = 1; b_pend = 0;
                    m_bresp = (b_idx == inj_b) ? 2'b10 : 2'b00;
                end else bdly--;
            end
            b_fire = m_bvalid && m_bready;
            if (m_awvalid) aw_seen++;
            m_awready = ($urandom_range(99) < rdy_pct);
            if (m_awvalid && m_awready) begin
                aw_log.push_back(m_awaddr);
                w_addr = m_awaddr; w_len = m_awlen; w_beat = 0;
                if (m_awsize !== 3'd6 || m_awburst !== 2'b01 || m_awid !== '0) fld_bad++;
            end
            m_wready = ($urandom_range(99) < rdy_pct);
            if (m_wvalid && m_wready) begin
                mem[w_addr + 32'(w_beat * BY)] = m_wdata;
                if (w_cnt == 0) w_lane0 = m_wdata[31:0];
                if (m_wdata !== pat(exp_seed, w_cnt)) w_bad++;
                if (m_wlast !== (w_beat == int'(w_len)) || m_wstrb !== '1) wlast_bad++;
                w_cnt++;
                if (w_beat == int'(w_len)) begin
                    b_pend = 1;
                    bdly = (rdy_pct < 100) ? int'($urandom_range(3)) : 0;
                end
                w_beat++;
            end
            m_arready = ($urandom_range(99) < rdy_pct);
            if (m_arvalid && m_arready) begin
                ar_log.push_back(m_araddr);
                r_addr = m_araddr; r_len = m_arlen; r_beat = 0; r_act = 1;
                if (m_arsize !== 3'd6 || m_arburst !== 2'b01 || m_arid !== '0) fld_bad++;
            end
        end
    end

    a_aw_hold: assert property (@(posedge clk) disable iff (rst)
        m_awvalid && !m_awready |=> m_awvalid && $stable({m_awaddr, m_awlen}))
        else aw_hold_f++;
    a_w_hold: assert property (@(posedge clk) disable iff (rst)
        m_wvalid && !m_wready |=> m_wvalid && $stable(m_wdata) && $stable(m_wlast))
        else w_hold_f++;
    a_ar_hold: assert property (@(posedge clk) disable iff (rst)
        m_arvalid && !m_arready |=> m_arvalid && $stable({m_araddr, m_arlen}))
        else ar_hold_f++;

    task automatic run(input string nm, input logic [31:0] base, input logic [7:0] len,
                       input logic [15:0] nb, input logic [31:0] sd, input int pct,
                       input int ib, input int ir, input bit poke);
        int          beats, exp_err, to, abad;
        logic [31:0] stride, exp_first;
        bit          legal;
        legal     = (base[11:0] == 12'd0) && (len inside {8'd0, 8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63});
        stride    = (32'(len) + 32'd1) * 32'(BY);
        beats     = legal ? int'(nb) * (int'(len) + 1) : 0;
        exp_err   = 0;
        exp_first = '0;
        if (legal && ir >= 0 && ir < beats) begin
            exp_err++; exp_first = base + 32'(ir) * 32'(BY);
        end
        // The write phase comes first, so a bad B response is the first error.
        if (legal && ib >= 0 && ib < int'(nb)) begin
            exp_err++; exp_first = base + 32'(ib) * stride;
        end

        @(negedge clk); #1;
        rdy_pct = pct; inj_b = ib; inj_r = ir; exp_seed = sd; clr_req++;
        base_addr = base; burst_len = len; num_bursts = nb; seed = sd; start = 1;
        @(negedge clk); #1;
        start = 0;
        if (!legal) chk({nm, "_cfg_flags"}, {busy, done, pass, cfg_err}, 4'b0101);
        else if (nb == 0) chk({nm, "_nb0_flags"}, {busy, done, pass, cfg_err}, 4'b0110);
        else begin
            chk({nm, "_aw_next"}, {busy, done, m_awvalid}, 3'b101);
            if (poke) begin
                repeat (4) @(negedge clk); #1;
                base_addr = 32'h40; num_bursts = 16'd9; seed = ~sd; start = 1;
                @(negedge clk); #1;
                start = 0;
            end
            to = 0;
            while (!done && to < 20000) begin
                @(negedge clk); #1;
                to++;
            end
            chk({nm, "_timeout"}, done, 1'b1);
        end
        repeat (3) @(negedge clk); #1;
        chk({nm, "_busy_done"}, {busy, done}, 2'b01);
        chk({nm, "_pass"}, pass, legal && exp_err == 0);
        chk({nm, "_cfg_err"}, cfg_err, !legal);
        chk({nm, "_err_count"}, err_count, 16'(exp_err));
        chk({nm, "_first_err"}, first_err_addr, exp_first);
        chk({nm, "_aw_cnt"}, aw_log.size(), legal ? nb : 16'd0);
        chk({nm, "_ar_cnt"}, ar_log.size(), legal ? nb : 16'd0);
        if (beats == 0) chk({nm, "_no_awvalid"}, aw_seen, 0);
        abad = 0;
        foreach (aw_log[i]) if (aw_log[i] !== base + 32'(i) * stride) abad++;
        foreach (ar_log[i]) if (ar_log[i] !== base + 32'(i) * stride) abad++;
        chk({nm, "_addr_bad"}, abad, 0);
        chk({nm, "_w_beats"}, w_cnt, beats);
        chk({nm, "_r_beats"}, r_g, beats);
        chk({nm, "_wdata_bad"}, w_bad, 0);
        chk({nm, "_wlast_strb_bad"}, wlast_bad, 0);
        chk({nm, "_ax_fields_bad"}, fld_bad, 0);
    endtask

    initial begin
        int         to;
        logic [7:0] lens [7];
        logic [7:0] ln;
        logic [15:0] nb;
        int         bt, ib, ir;
        lens = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63};

        rst = 1; start = 0; base_addr = '0; burst_len = '0; num_bursts = '0; seed = '0;
        #1;
        chk("rst_flags", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                          busy, done, pass, cfg_err}, 9'd0);
        chk("rst_err_count", err_count, 16'd0);
        chk("rst_first_err", first_err_addr, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst = 0;

        run("t1", 32'h1000, 8'd3, 16'd2, 32'hA5A50000, 100, -1, -1, 0);
        chk("t1_aw0", (aw_log.size() > 0) ? aw_log[0] : 32'hFFFF_FFFF, 32'h1000);
        chk("t1_aw1", (aw_log.size() > 1) ? aw_log[1] : 32'hFFFF_FFFF, 32'h1100);
        chk("t1_lane0", w_lane0, 32'hA5A50000);

        run("t2", 32'h1000, 8'd3, 16'd2, 32'hA5A50000, 30, -1, -1, 1);
        run("t3", 32'h1000, 8'd3, 16'd2, 32'hA5A50000, 100, -1, 5, 0);
        run("t4", 32'h1000, 8'd3, 16'd2, 32'hA5A50000, 100, 0, -1, 0);
        run("t5a", 32'h1040, 8'd3, 16'd2, 32'h1, 100, -1, -1, 0);
        run("t5b", 32'h1000, 8'd2, 16'd2, 32'h2, 100, -1, -1, 0);
        run("t5c", 32'h2000, 8'd7, 16'd0, 32'h3, 100, -1, -1, 0);

        // Reset in the middle of the write data phase.
        @(negedge clk); #1;
        rdy_pct = 100; inj_b = -1; inj_r = -1; exp_seed = 32'h1234; clr_req++;
        base_addr = 32'h1000; burst_len = 8'd3; num_bursts = 16'd2; seed = 32'h1234; start = 1;
        @(negedge clk); #1;
        start = 0;
        to = 0;
        while (w_cnt < 2 && to < 1000) begin
            @(negedge clk); #1;
            to++;
        end
        @(posedge clk); #2;
        chk("t6_wvalid_pre", m_wvalid, 1'b1);
        rst = 1;
        #1;
        chk("t6_rst_now", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy, done}, 7'd0);
        chk("t6_rst_err", err_count, 16'd0);
        repeat (2) @(negedge clk);
        #1 rst = 0;
        run("t6b", 32'h1000, 8'd3, 16'd2, 32'h1234, 100, -1, -1, 0);

        for (int it = 0; it < 6; it++) begin
            ln = lens[$urandom_range(6)];
            nb = 16'($urandom_range(1, 4));
            bt = int'(nb) * (int'(ln) + 1);
            ib = ($urandom_range(3) == 0) ? int'($urandom_range(int'(nb) - 1)) : -1;
            ir = ($urandom_range(3) == 0) ? int'($urandom_range(bt - 1)) : -1;
            run($sformatf("rnd%0d", it), {4'd0, 16'($urandom), 12'd0}, ln, nb, $urandom,
                int'($urandom_range(30, 100)), ib, ir, 0);
        end

        chk("aw_payload_hold", aw_hold_f, 0);
        chk("w_payload_hold", w_hold_f, 0);
        chk("ar_payload_hold", ar_hold_f, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
